cdb_broadcast_queue: RTL and testbench
======================================

# cdb_broadcast_queue

Collects completed results from the execution functional units and serialises them onto the common data bus (CDB), one result per cycle. It sits directly downstream of every FU: it takes each FU's one-cycle `done` pulse with its tag and result, and returns `queued` in the same cycle. An FU returns to idle only after it sees `done & queued`. Queued results are presented in arrival order to the CDB consumers (reservation stations, register file, ROB) through a valid/ready handshake.

## Interface
- `NUM_FU`, 4: number of FU input lanes.
- `DATA_WIDTH`, 32: result width.
- `TAG_WIDTH`, 7: execution tag width.
- `DEPTH`, 8: queue entries; power of two, at least `NUM_FU`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fu_done` in NUM_FU: per-lane result-valid pulse. It lasts one cycle.
- `fu_tag` in NUM_FU*TAG_WIDTH: per-lane tag. Lane i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- `fu_result` in NUM_FU*DATA_WIDTH: per-lane result, packed the same way.
- `fu_queued` out NUM_FU: combinational accept, per lane, in the same cycle as `fu_done`.
- `flush` in 1: synchronous discard of all queued and incoming results.
- `cdb_valid` out 1: a head entry is present.
- `cdb_tag` out TAG_WIDTH: tag of the head entry.
- `cdb_data` out DATA_WIDTH: result of the head entry.
- `cdb_ready` in 1: the consumer takes the head entry this cycle.
- `count` out clog2(DEPTH)+1: number of occupied entries.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `drop_count` out 16: refused-result counter. See Configuration.

## Operation
- The queue is a circular buffer with head pointer, tail pointer and count registers. Pointers are clog2(DEPTH) bits and wrap naturally at DEPTH.
- Free space is `free = DEPTH - count`. Free space is computed from registered count only; a pop in the same cycle does not create space for a push. This keeps `cdb_ready` out of the `fu_queued` path.
- Grant rule: lanes with `fu_done=1` are granted in ascending index order until `free` is exhausted.
  - `fu_queued[i] = fu_done[i] & granted[i]`.
  - A refused lane gets `fu_queued=0`. Its result is lost and that FU stays non-idle.
  - Dispatch must size DEPTH and FU occupancy so that refusal never occurs in normal operation.
- Push: granted lanes are written to consecutive slots starting at the tail, lowest index first. The tail advances by the number of granted lanes.
- Pop: when `cdb_valid & cdb_ready`, the head advances by 1.
- Count update: `count_next = count + granted - pop`.
- Simultaneous push and pop: both take effect at the same edge.
- Flush:
  - Next edge: head, tail and count go to 0.
  - During a flush cycle, `fu_queued = fu_done` so that FUs are released, but nothing is written.
  - A pop during the flush cycle is ignored.
- CDB outputs:
  - `cdb_valid = ~empty`.
  - `cdb_tag` and `cdb_data` come from the head entry and are forced to 0 when empty.
  - While `cdb_valid & ~cdb_ready`, the outputs are held stable.
- Memory contents are not reset. Only pointers and count are reset.

## Timing
- Reset (`rst=0`, asynchronous), outputs:
  - `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`.
  - `count=0`, `empty=1`, `full=0`.
  - `drop_count=0`, `fu_queued=0` (forced while in reset).
- `fu_queued` depends only on `fu_done`, `flush` and registered count. Its latency is 0 cycles.
- Latency, done to CDB:
  - `fu_done` in cycle t into an empty queue gives `cdb_valid=1` in cycle t+1.
  - Otherwise the result appears after all older entries have popped.
- Same-cycle ordering: several lanes done in the same cycle appear on the CDB in ascending lane order on consecutive pops.
- Throughput: at most one pop per cycle, and up to NUM_FU pushes per cycle.
- Full queue: all `fu_done` lanes are refused that cycle, even if `cdb_ready=1`.

## Configuration
- Macro: `CDB_BQ_DROP_CNT_EN`.
- Defined: `drop_count` increments by 1 in every non-flush cycle in which any `fu_done` lane is refused. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the counter logic is not built, and `drop_count` is constant 0.

## Test plan
- Reset, then single result:
  - Stimulus: release `rst`; pulse lane 0 `fu_done` with tag 5, data 0x10, `cdb_ready=1`.
  - Response: `fu_queued[0]=1` in that cycle; the next cycle shows `cdb_valid=1`, tag 5, data 0x10; then `empty=1`.
- Simultaneous lanes:
  - Stimulus: lanes 3, 1 and 0 done in the same cycle with tags 30, 10, 0.
  - Response: all are queued; the CDB emits tags 0, 10, 30 on three consecutive cycles; `count` goes 3, 2, 1, 0.
- Backpressure and overflow:
  - Stimulus: `DEPTH=8`, `cdb_ready=0`; fill to 7 entries, then lanes 0 and 2 done together.
  - Response: lane 0 is queued and lane 2 refused; `full=1`; `drop_count=1` with the macro, 0 without.
- Wrap-around:
  - Stimulus: push and pop 20 results with tags 0..19, streamed one per cycle, `cdb_ready=1`.
  - Response: tags emerge in order 0..19 with no gaps; `count` never exceeds 1.
- Flush:
  - Stimulus: with 4 entries queued, assert `flush` together with lane 1 done.
  - Response: `fu_queued[1]=1`; the next cycle shows `count=0`, `cdb_valid=0`, and no trace of lane 1's result.
- Asynchronous reset mid-operation:
  - Stimulus: with 5 entries queued, drop `rst` between clock edges.
  - Response: `cdb_valid=0` and `count=0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdb_broadcast_queue_if.sv
// Bundle of FU-side result lanes and CDB-side consumer handshake for cdb_broadcast_queue.
// The slave modport is the queue itself; the master modport is the surrounding pipeline.
interface cdb_broadcast_queue_if #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_FU-1:0]            fu_done;
  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag;
  logic [NUM_FU*DATA_WIDTH-1:0] fu_result;
  logic [NUM_FU-1:0]            fu_queued;
  logic                         flush;
  logic                         cdb_valid;
  logic [TAG_WIDTH-1:0]         cdb_tag;
  logic [DATA_WIDTH-1:0]        cdb_data;
  logic                         cdb_ready;
  logic [CW-1:0]                count;
  logic                         full;
  logic                         empty;
  logic [15:0]                  drop_count;

  modport slave (
    input  fu_done, fu_tag, fu_result, flush, cdb_ready,
    output fu_queued, cdb_valid, cdb_tag, cdb_data, count, full, empty, drop_count
  );

  modport master (
    output fu_done, fu_tag, fu_result, flush, cdb_ready,
    input  fu_queued, cdb_valid, cdb_tag, cdb_data, count, full, empty, drop_count
  );
endinterface

// File: rtl/cdb_broadcast_queue.sv
// Circular result queue merging NUM_FU completion lanes onto the CDB, one pop per cycle.
// Optional refused-result counter is built when CDB_BQ_DROP_CNT_EN is defined.
module cdb_broadcast_queue #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cdb_broadcast_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_WIDTH-1:0]  lane_tag  [NUM_FU];
  logic [DATA_WIDTH-1:0] lane_data [NUM_FU];

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_lane
      assign lane_tag[gi]  = bus.fu_tag[gi*TAG_WIDTH +: TAG_WIDTH];
      assign lane_data[gi] = bus.fu_result[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0]     free;
  logic [CW-1:0]     n_grant;
  logic [NUM_FU-1:0] granted;
  logic [NUM_FU-1:0] wr_en;
  logic [PW-1:0]     wr_ptr [NUM_FU];
  logic              is_empty;
  logic              pop;

  // Space comes from registered count only, so cdb_ready never reaches fu_queued.
  assign free     = CW'(DEPTH) - count_q;
  assign is_empty = (count_q == '0);
  assign pop      = ~is_empty & bus.cdb_ready & ~bus.flush;

  always_comb begin
    n_grant = '0;
    granted = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      wr_ptr[i] = tail_q + n_grant[PW-1:0];
      if (bus.fu_done[i] && (n_grant < free)) begin
        granted[i] = 1'b1;
        n_grant    = n_grant + CW'(1);
      end
    end
  end

  assign wr_en         = bus.flush ? '0 : granted;
  assign bus.fu_queued = !rst ? '0 : (bus.flush ? bus.fu_done : granted);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      tail_d  = tail_q + n_grant[PW-1:0];
      head_d  = head_q + PW'(pop);
      count_d = count_q + n_grant - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only pointers define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (wr_en[i]) begin
        tag_mem[wr_ptr[i]]  <= lane_tag[i];
        data_mem[wr_ptr[i]] <= lane_data[i];
      end
    end
  end

  assign bus.cdb_valid = ~is_empty;
  assign bus.cdb_tag   = is_empty ? '0 : tag_mem[head_q];
  assign bus.cdb_data  = is_empty ? '0 : data_mem[head_q];
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(DEPTH));
  assign bus.empty     = is_empty;

`ifdef CDB_BQ_DROP_CNT_EN
  logic [15:0] drop_q;
  logic        refused;

  assign refused = ~bus.flush & (|(bus.fu_done & ~granted));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (refused && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// Self-checking bench for cdb_broadcast_queue: directed vector table, corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_cdb_broadcast_queue;
  localparam int NF = 4;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int DP = 8;
`ifdef CDB_BQ_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_broadcast_queue_if #(.NUM_FU(NF), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DP)) bus ();

  cdb_broadcast_queue #(.NUM_FU(NF), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_drop;
  logic [NF-1:0] m_eq;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [NF-1:0]    done;
    logic [NF*TW-1:0] tags;
    logic             ready;
    logic             flush;
    logic [NF-1:0]    eq;
    int               ecount;
    logic             evalid;
    logic [TW-1:0]    etag;
    logic             efull;
  } vec_t;

  vec_t vt[$];

  function automatic logic [DW-1:0] dfun(input logic [TW-1:0] t);
    return DW'((int'(t) - 4) * 16);
  endfunction

  function automatic vec_t mkv(input logic [3:0] done, input int t3, input int t2, input int t1,
                               input int t0, input logic ready, input logic flush,
                               input logic [3:0] eq, input int ecount, input logic evalid,
                               input int etag, input logic efull);
    vec_t v;
    v.done  = done;
    v.tags  = {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
    v.ready = ready;
    v.flush = flush;
    v.eq    = eq;
    v.ecount = ecount;
    v.evalid = evalid;
    v.etag  = TW'(etag);
    v.efull = efull;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [NF-1:0] done, input logic [NF*TW-1:0] tags,
                       input logic ready, input logic flush);
    bus.fu_done   = done;
    bus.fu_tag    = tags;
    bus.cdb_ready = ready;
    bus.flush     = flush;
    for (int i = 0; i < NF; i++) bus.fu_result[i*DW +: DW] = dfun(tags[i*TW +: TW]);
  endtask

  // Reference: accept lanes in index order while queue space (pre-pop) remains.
  task automatic model_check();
    int free;
    m_eq = '0;
    if (bus.flush) m_eq = bus.fu_done;
    else begin
      free = DP - mq.size();
      for (int i = 0; i < NF; i++)
        if (bus.fu_done[i] && free > 0) begin
          m_eq[i] = 1'b1;
          free--;
        end
    end
    chk("fu_queued", 64'(bus.fu_queued), 64'(m_eq));
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(mq.size() > 0));
    chk("cdb_tag", 64'(bus.cdb_tag), mq.size() > 0 ? 64'(mq[0].tag) : 64'd0);
    chk("cdb_data", 64'(bus.cdb_data), mq.size() > 0 ? 64'(mq[0].data) : 64'd0);
    chk("full", 64'(bus.full), 64'(mq.size() == DP));
    chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
    chk("drop_count", 64'(bus.drop_count), DROP_EN ? 64'(m_drop) : 64'd0);
  endtask

  task automatic model_commit();
    ent_t e;
    bit   popped;
    popped = (mq.size() > 0) && bus.cdb_ready && !bus.flush;
    $display("t=%0t done=%b queued=%b ready=%b flush=%b count=%0d pop=%0d tag=%0d",
             $time, bus.fu_done, bus.fu_queued, bus.cdb_ready, bus.flush, bus.count,
             popped, bus.cdb_tag);
    if (bus.flush) mq.delete();
    else begin
      if ((|(bus.fu_done & ~m_eq)) && m_drop < 65535) m_drop++;
      if (popped) void'(mq.pop_front());
      for (int i = 0; i < NF; i++)
        if (m_eq[i]) begin
          e.tag  = bus.fu_tag[i*TW +: TW];
          e.data = bus.fu_result[i*DW +: DW];
          mq.push_back(e);
        end
    end
  endtask

  task automatic step();
    #4;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(bus.cdb_valid), 64'd0);
    chk({tag, "_tag"}, 64'(bus.cdb_tag), 64'd0);
    chk({tag, "_data"}, 64'(bus.cdb_data), 64'd0);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
    chk({tag, "_full"}, 64'(bus.full), 64'd0);
    chk({tag, "_drop"}, 64'(bus.drop_count), 64'd0);
    chk({tag, "_queued"}, 64'(bus.fu_queued), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_drop   = 0;
    drive(4'b1111, {TW'(1), TW'(2), TW'(3), TW'(4)}, 1'b1, 1'b0);
    #12;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b1;
    drive('0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

    // {done, tag3, tag2, tag1, tag0, ready, flush, exp_queued, exp_count, exp_valid, exp_tag, exp_full}
    vt.push_back(mkv(4'b0001, 0, 0, 0, 5, 1, 0, 4'b0001, 0, 0, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 1, 5, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mkv(4'b1011, 30, 0, 10, 0, 1, 0, 4'b1011, 0, 0, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 3, 1, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 1, 10, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 1, 1, 30, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mkv(4'b1111, 43, 42, 41, 40, 0, 0, 4'b1111, 0, 0, 0, 0));
    vt.push_back(mkv(4'b0111, 0, 46, 45, 44, 0, 0, 4'b0111, 4, 1, 40, 0));
    vt.push_back(mkv(4'b0101, 0, 48, 0, 47, 0, 0, 4'b0001, 7, 1, 40, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 8, 1, 40, 1));
    vt.push_back(mkv(4'b0011, 0, 0, 51, 50, 1, 0, 4'b0000, 8, 1, 40, 1));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 0, 0, 4'b0000, 7, 1, 41, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 7, 1, 41, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 6, 1, 42, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 5, 1, 43, 0));
    vt.push_back(mkv(4'b0010, 0, 0, 99, 0, 1, 1, 4'b0010, 4, 1, 44, 0));
    vt.push_back(mkv(4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0));

    for (int v = 0; v < vt.size(); v++) begin
      drive(vt[v].done, vt[v].tags, vt[v].ready, vt[v].flush);
      step();
      chk($sformatf("vec%0d_queued", v), 64'(bus.fu_queued), 64'(vt[v].eq));
      chk($sformatf("vec%0d_count", v), 64'(bus.count), 64'(vt[v].ecount));
      chk($sformatf("vec%0d_valid", v), 64'(bus.cdb_valid), 64'(vt[v].evalid));
      chk($sformatf("vec%0d_tag", v), 64'(bus.cdb_tag), 64'(vt[v].etag));
      chk($sformatf("vec%0d_data", v), 64'(bus.cdb_data),
          vt[v].evalid ? 64'(dfun(vt[v].etag)) : 64'd0);
      chk($sformatf("vec%0d_full", v), 64'(bus.full), 64'(vt[v].efull));
      tick();
    end
    chk("drop_after_overflow", 64'(bus.drop_count), DROP_EN ? 64'd2 : 64'd0);

    // Streamed wrap-around: 20 tags through the circular buffer, one per cycle.
    for (int i = 0; i < 20; i++) begin
      logic [NF*TW-1:0] tg;
      tg = '0;
      tg[(i % NF)*TW +: TW] = TW'(i);
      drive(NF'(1) << (i % NF), tg, 1'b1, 1'b0);
      step();
      if (i > 0) begin
        chk($sformatf("wrap%0d_tag", i), 64'(bus.cdb_tag), 64'(i - 1));
        chk($sformatf("wrap%0d_count", i), 64'(bus.count), 64'd1);
      end
      tick();
    end
    drive('0, '0, 1'b1, 1'b0);
    step();
    chk("wrap_last_tag", 64'(bus.cdb_tag), 64'd19);
    tick();
    step();
    chk("wrap_drained", 64'(bus.empty), 64'd1);
    tick();

    // Asynchronous reset with five entries queued.
    drive(4'b1111, {TW'(63), TW'(62), TW'(61), TW'(60)}, 1'b0, 1'b0);
    step();
    tick();
    drive(4'b0001, {TW'(0), TW'(0), TW'(0), TW'(64)}, 1'b0, 1'b0);
    step();
    tick();
    drive(4'b1111, {TW'(1), TW'(2), TW'(3), TW'(4)}, 1'b0, 1'b0);
    step();
    chk("pre_areset_count", 64'(bus.count), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    reset_checks("areset");
    mq.delete();
    m_drop = 0;
    @(posedge clk);
    #1;
    reset_checks("areset_hold");
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic: low-ready phase to provoke full/refusal, then mostly-ready phase.
    for (int c = 0; c < 600; c++) begin
      logic [NF*TW-1:0] tg;
      logic rdy;
      logic fl;
      for (int i = 0; i < NF; i++) tg[i*TW +: TW] = TW'($urandom);
      rdy = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 49) == 0);
      drive(NF'($urandom) & NF'($urandom), tg, rdy, fl);
      for (int i = 0; i < NF; i++) bus.fu_result[i*DW +: DW] = $urandom;
      step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
